serial_sub4: RTL and testbench

Bit-serial subtractor: accepts two WIDTH-bit unsigned operands plus a borrow-in, computes `a - b - bin` one bit per clock through a single full-subtractor cell and a registered borrow, and presents the difference and borrow-out with a one-cycle done pulse. It is the subtract-direction companion to the team's ripple-carry 4-bit adder. It trades WIDTH cycles of latency for one cell of logic, and sits where area matters more than throughput, such as control-path counters and compare-by-subtract.

---
 rtl/serial_sub4_if.sv | 45 ++++
 rtl/serial_sub4.sv | 139 +++++++++++++
 tb/tb_serial_sub4.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_sub4_if.sv
// serial_sub4_if -- handshake/data bundle for the bit-serial subtractor.
//
// Optional feature macro: SERIAL_SUB4_OVF_EN (adds the ovf signal).
//
// Signals:
//   start        request; taken only when busy is low
//   a, b, bin    minuend, subtrahend, borrow-in (sampled at acceptance)
//   busy         operation in flight
//   done         one-cycle completion pulse
//   diff, bout   (a - b - bin) mod 2^WIDTH and unsigned borrow-out
//   ovf          two's-complement overflow (SERIAL_SUB4_OVF_EN only)
//
// Modports: master drives requests (testbench/initiator), slave is the
// subtractor itself.
interface serial_sub4_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SERIAL_SUB4_OVF_EN
    logic             ovf;
`endif

    modport master (
        output start, a, b, bin,
`ifdef SERIAL_SUB4_OVF_EN
        input  ovf,
`endif
        input  busy, done, diff, bout
    );

    modport slave (
        input  start, a, b, bin,
`ifdef SERIAL_SUB4_OVF_EN
        output ovf,
`endif
        output busy, done, diff, bout
    );
endinterface

// File: rtl/serial_sub4.sv
// serial_sub4 -- bit-serial subtractor computing a - b - bin one bit per
// clock through a single full-subtractor cell and a registered borrow.
//
// Optional feature macro: SERIAL_SUB4_OVF_EN -- when defined, a registered
// two's-complement overflow flag (bus.ovf) is produced on completion.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    serial_sub4_if.slave: start/a/b/bin in; busy/done/diff/bout
//          (and ovf) out, all outputs registered
//
// Timing: start accepted at edge k (busy low) -> bits processed at edges
// k+1..k+WIDTH -> done pulse, diff/bout updated and busy low after k+WIDTH.
module serial_sub4 #(
    parameter int WIDTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    serial_sub4_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    // Only WIDTH-1 partial bits are kept: the final difference bit is
    // concatenated directly on the completion edge.
    logic [WIDTH-2:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
    logic             done_q, done_d;
`ifdef SERIAL_SUB4_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic             ai, bi, di, br_next;
    logic [WIDTH-1:0] res_shift;

    always_comb begin
        ai        = a_q[0];
        bi        = b_q[0];
        di        = ai ^ bi ^ br_q;
        br_next   = (~ai & bi) | (~(ai ^ bi) & br_q);
        res_shift = {di, res_q};

        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        bout_d  = bout_q;
        done_d  = 1'b0;
`ifdef SERIAL_SUB4_OVF_EN
        ovf_d   = ovf_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    br_d    = bus.bin;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                res_d = res_shift[WIDTH-1:1];
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = br_next;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    // Last bit: publish result; start is not sampled here,
                    // so a request on this edge is dropped.
                    diff_d  = res_shift;
                    bout_d  = br_next;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
`ifdef SERIAL_SUB4_OVF_EN
                    // br_q is the borrow into the MSB on this edge.
                    ovf_d   = br_q ^ br_next;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_SUB4_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
            done_q  <= done_d;
`ifdef SERIAL_SUB4_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.busy = (state_q == SHIFT);
    assign bus.done = done_q;
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
`ifdef SERIAL_SUB4_OVF_EN
    assign bus.ovf  = ovf_q;
`endif
endmodule

// File: tb/tb_serial_sub4.sv
// tb_serial_sub4 -- self-checking bench for serial_sub4 at WIDTH=4 and
// WIDTH=16. Expected results come from an arithmetic model and travel
// through per-width scoreboard queues.
module tb_serial_sub4;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    serial_sub4_if #(.WIDTH(4))  bus4 ();
    serial_sub4_if #(.WIDTH(16)) bus16 ();

    serial_sub4 #(.WIDTH(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4));
    serial_sub4 #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

    typedef struct {
        logic [31:0] diff;
        logic        bout;
        logic        ovf;
    } exp_t;

    exp_t q4[$];
    exp_t q16[$];
    int   vectors     = 0;
    int   miscompares = 0;

    function automatic exp_t model(input int w, input logic [31:0] a,
                                   input logic [31:0] b, input logic bin);
        exp_t   e;
        longint ua, ub, ubin, half, full, sa, sb, sr;
        ua     = longint'(a);
        ub     = longint'(b);
        ubin   = bin ? 64'sd1 : 64'sd0;
        full   = 64'sd1 << w;
        half   = 64'sd1 << (w - 1);
        e.diff = 32'((ua - ub - ubin) & (full - 1));
        e.bout = (ua < ub + ubin);
        sa     = (ua >= half) ? ua - full : ua;
        sb     = (ub >= half) ? ub - full : ub;
        sr     = sa - sb - ubin;
        e.ovf  = (sr < -half) || (sr > half - 1);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Drive a request at a falling edge; returns at the falling edge just
    // after the accepting rising edge with start already released.
    task automatic launch4(input logic [3:0] a, input logic [3:0] b, input logic bin,
                           input bit push);
        @(negedge clk);
        check("done_single_cycle", bus4.done, 1'b0);
        bus4.a     = a;
        bus4.b     = b;
        bus4.bin   = bin;
        bus4.start = 1'b1;
        if (push) q4.push_back(model(4, a, b, bin));
        @(negedge clk);
        bus4.start = 1'b0;
    endtask

    // Wait (bounded) for done; elat/ebusy are the falling edges still to go.
    task automatic collect4(input int elat, input int ebusy);
        int   lat = 0;
        int   bc  = 0;
        exp_t e;
        while (lat < 40 && bus4.done !== 1'b1) begin
            if (bus4.busy === 1'b1) bc++;
            @(negedge clk);
            lat++;
        end
        vectors++;
        check("latency4", lat, elat);
        check("busy_cycles4", bc, ebusy);
        assert (q4.size() != 0) else begin
            miscompares++;
            $error("FAIL scoreboard4: observed empty expected entry");
        end
        if (q4.size() != 0) begin
            e = q4.pop_front();
            check("diff4", bus4.diff, e.diff);
            check("bout4", bus4.bout, e.bout);
`ifdef SERIAL_SUB4_OVF_EN
            check("ovf4", bus4.ovf, e.ovf);
`endif
        end
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic bin);
        int   lat = 0;
        exp_t e;
        @(negedge clk);
        bus16.a     = a;
        bus16.b     = b;
        bus16.bin   = bin;
        bus16.start = 1'b1;
        q16.push_back(model(16, a, b, bin));
        @(negedge clk);
        bus16.start = 1'b0;
        while (lat < 60 && bus16.done !== 1'b1) begin
            @(negedge clk);
            lat++;
        end
        vectors++;
        check("latency16", lat, 16);
        e = q16.pop_front();
        check("diff16", bus16.diff, e.diff);
        check("bout16", bus16.bout, e.bout);
`ifdef SERIAL_SUB4_OVF_EN
        check("ovf16", bus16.ovf, e.ovf);
`endif
    endtask

    initial begin
        int ndone;
        bus4.start  = 1'b0; bus4.a  = '0; bus4.b  = '0; bus4.bin  = 1'b0;
        bus16.start = 1'b0; bus16.a = '0; bus16.b = '0; bus16.bin = 1'b0;

        // Reset values
        #1 rst_n = 1'b0;
        #1;
        check("rst_busy", bus4.busy, 1'b0);
        check("rst_done", bus4.done, 1'b0);
        check("rst_diff", bus4.diff, 4'h0);
        check("rst_bout", bus4.bout, 1'b0);
`ifdef SERIAL_SUB4_OVF_EN
        check("rst_ovf", bus4.ovf, 1'b0);
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Basic subtract and underflow
        launch4(4'd9, 4'd3, 1'b0, 1'b1); collect4(4, 4);
        launch4(4'd3, 4'd9, 1'b0, 1'b1); collect4(4, 4);
        launch4(4'd0, 4'd0, 1'b1, 1'b1); collect4(4, 4);
        // Signed overflow corners
        launch4(4'd8, 4'd1, 1'b0, 1'b1); collect4(4, 4);
        launch4(4'd7, 4'd7, 1'b0, 1'b1); collect4(4, 4);

        // start on the 2nd busy edge with other operands must be ignored
        launch4(4'd9, 4'd3, 1'b0, 1'b1);
        @(negedge clk);
        bus4.a = 4'd1; bus4.b = 4'd2; bus4.bin = 1'b1; bus4.start = 1'b1;
        @(negedge clk);
        bus4.start = 1'b0;
        collect4(2, 2);

        // Continuous start: one acceptance every 5 edges
        @(negedge clk);
        bus4.a = 4'd5; bus4.b = 4'd2; bus4.bin = 1'b0; bus4.start = 1'b1;
        repeat (5) q4.push_back(model(4, 5, 2, 1'b0));
        ndone = 0;
        for (int i = 0; i < 21; i++) begin
            exp_t e;
            @(negedge clk);
            if (bus4.done === 1'b1) begin
                ndone++;
                vectors++;
                check("cont_phase", i % 5, 4);
                e = q4.pop_front();
                check("cont_diff", bus4.diff, e.diff);
                check("cont_bout", bus4.bout, e.bout);
            end
        end
        bus4.start = 1'b0;
        check("cont_count", ndone, 4);
        collect4(4, 4);

        // Reset two cycles into an operation
        launch4(4'd7, 4'd2, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", bus4.busy, 1'b0);
        check("mid_rst_done", bus4.done, 1'b0);
        check("mid_rst_diff", bus4.diff, 4'h0);
        check("mid_rst_bout", bus4.bout, 1'b0);
`ifdef SERIAL_SUB4_OVF_EN
        check("mid_rst_ovf", bus4.ovf, 1'b0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus4.done === 1'b1 || bus4.busy === 1'b1) ndone++;
        end
        check("no_done_after_rst", ndone, 0);
        launch4(4'd15, 4'd1, 1'b0, 1'b1); collect4(4, 4);

        // Exhaustive WIDTH=4
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 2; c++) begin
                    launch4(4'(a), 4'(b), 1'(c), 1'b1);
                    collect4(4, 4);
                end

        // WIDTH=16 corners then random vectors
        op16(16'h0000, 16'h0000, 1'b1);
        op16(16'hFFFF, 16'h0000, 1'b0);
        op16(16'h8000, 16'h0001, 1'b0);
        op16(16'h7FFF, 16'hFFFF, 1'b1);
        for (int i = 0; i < 2000; i++)
            op16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
